mem_bus_arbiter: RTL and testbench

//  Shares one external memory bus between the core's instruction-fetch port and its MEM-stage data port.

---
 rtl/mem_bus_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory bus between the instruction-fetch
// port and the MEM-stage data port of the core. Requests are serialised by a
// small FSM; bus latency is turned into rom_stall / ram_stall, read data is held
// in a holding register, and bus timeouts set a sticky error flag.
// Optional feature: define INST_BUF_EN to add a one-entry fetch buffer that
// serves repeated fetches of the same word without touching the bus.
module mem_bus_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rom_cs,
  input  logic        inst_ren,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  output logic        rom_stall,
  input  logic        ram_cs,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        ram_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } state_t;

  // Last counter value before a timeout fires; unused when TIMEOUT is 0.
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

  state_t          state_q;
  logic            bus_req_q;
  logic            bus_we_q;
  logic [31:0]     bus_addr_q;
  logic [31:0]     bus_wdata_q;
  logic            bus_err_q;
  logic [31:0]     hold_q;
  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  logic fetchReq;
  logic dataReq;
  logic inBusy;
  logic timeoutHit;
  logic bufHit;

  // The two byte-offset bits never reach the word-aligned bus.
  logic unused_lowBits;
  assign unused_lowBits = ^{inst_addr[1:0], mem_addr[1:0]};

  assign fetchReq   = rom_cs & inst_ren;
  assign dataReq    = ram_cs & (mem_ren | mem_wen);
  assign inBusy     = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign timeoutHit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

`ifdef INST_BUF_EN
  logic        bufValid_q;
  logic [29:0] bufTag_q;
  logic [31:0] bufData_q;

  // A hit is only honoured while idle and with no data request competing,
  // so the buffer never changes the data-first ordering.
  assign bufHit = (state_q == IDLE) & fetchReq & bufValid_q &
                  (bufTag_q == inst_addr[31:2]) & ~dataReq;

  // Fill on every acknowledged fetch; drop the entry when a write to the same word is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bufValid_q <= 1'b0;
      bufTag_q   <= '0;
      bufData_q  <= '0;
    end else if ((state_q == BUSY_I) && bus_ack) begin
      bufValid_q <= 1'b1;
      bufTag_q   <= bus_addr_q[31:2];
      bufData_q  <= bus_rdata;
    end else if ((state_q == IDLE) && dataReq && mem_wen &&
                 (bufTag_q == mem_addr[31:2])) begin
      bufValid_q <= 1'b0;
    end
  end

  assign inst_data = bufHit ? bufData_q : hold_q;
`else
  assign bufHit    = 1'b0;
  assign inst_data = hold_q;
`endif

  assign mem_din = hold_q;

  // A requester stalls until its own DONE cycle; a buffer hit completes at once.
  assign rom_stall = fetchReq & ~(state_q == DONE_I) & ~bufHit;
  assign ram_stall = dataReq & ~(state_q == DONE_D);

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_err   = bus_err_q;

  // Timeout counter counts completed BUSY cycles and is cleared whenever a transaction ends.
  always_comb begin
    cnt_d = '0;
    if (inBusy && !bus_ack && !timeoutHit) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  // Main FSM: issues one bus transaction at a time and registers every bus output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_err_q   <= 1'b0;
      hold_q      <= '0;
      cnt_q       <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: begin
          if (dataReq) begin
            state_q     <= BUSY_D;
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_wen;
            bus_addr_q  <= {mem_addr[31:2], 2'b00};
            bus_wdata_q <= mem_dout;
          end else if (fetchReq && !bufHit) begin
            state_q     <= BUSY_I;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= {inst_addr[31:2], 2'b00};
            bus_wdata_q <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus_ack) begin
            bus_req_q <= 1'b0;
            if ((state_q == BUSY_I) || !bus_we_q) begin
              hold_q <= bus_rdata;
            end
            state_q <= (state_q == BUSY_I) ? DONE_I : DONE_D;
          end else if (timeoutHit) begin
            bus_req_q <= 1'b0;
            bus_err_q <= 1'b1;
            hold_q    <= '0;
            state_q   <= (state_q == BUSY_I) ? DONE_I : DONE_D;
          end
        end
        DONE_I, DONE_D: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: acts as both the core and the memory bus.
// Expected stall lengths, read data, bus transactions and error state come from
// a transaction-level model of the arbiter's rules kept in this file.
module tb_mem_bus_arbiter;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rom_cs, inst_ren;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        rom_stall;
  logic        ram_cs, mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_dout;
  logic [31:0] mem_din;
  logic        ram_stall;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  mem_bus_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rom_cs    (rom_cs),
    .inst_ren  (inst_ren),
    .inst_addr (inst_addr),
    .inst_data (inst_data),
    .rom_stall (rom_stall),
    .ram_cs    (ram_cs),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .ram_stall (ram_stall),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          dly;
  } txn_t;

  int checkCount = 0;
  int passCount  = 0;

  // busMem is what the bus really holds; refMem is what the core should observe.
  logic [31:0] busMem [0:4095];
  logic [31:0] refMem [0:4095];

  logic        errExp;
  logic        bufValid;
  logic [29:0] bufTag;
  logic [31:0] bufData;

  logic [31:0] busAddrLog [$];
  int          busyLenLog [$];
  int          gapLog [$];

  // Compares one observed value against the model and logs any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Number of BUSY cycles a transaction takes: the ack delay, or the timeout if none comes.
  function automatic int lat(input int d);
    return ((d == 0) || (d > TIMEOUT)) ? TIMEOUT : d;
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'(a[13:2]);
  endfunction

  // Drops all core requests and resets DUT and model together.
  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    rom_cs = 1'b0; inst_ren = 1'b0; inst_addr = '0;
    ram_cs = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_dout = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    #1;
    checkOutput("rstBusReq", bus_req, 0);
    checkOutput("rstBusAddr", bus_addr, 0);
    checkOutput("rstBusErr", bus_err, 0);
    checkOutput("rstMemDin", mem_din, 0);
    checkOutput("rstInstData", inst_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    errExp   = 1'b0;
    bufValid = 1'b0;
    bufTag   = '0;
    bufData  = '0;
  endtask

  // Issues an optional fetch and an optional data access in the same cycle, plays
  // the memory bus with the given ack delays (0 = never ack), and checks the result.
  task automatic applyStimulus(input bit fEn, input logic [31:0] fAddr,
                               input bit dEn, input bit dWr, input logic [31:0] dAddr,
                               input logic [31:0] dWdata, input int fDly, input int dDly);
    txn_t        expQ [$];
    txn_t        t;
    int          fDoneExp, dDoneExp, fDoneCyc, dDoneCyc, nextFree;
    int          txnIdx, busyCnt, gapCnt, badBus;
    logic [31:0] fDataExp, dDataExp, fData, dData;
    bit          fDone, dDone, inTxn, fHit;

    // Reference model: data is served first, then the fetch once the arbiter is idle again.
    nextFree = 0;
    fDoneExp = -1; dDoneExp = -1;
    fDataExp = '0; dDataExp = '0;
    if (dEn) begin
      t.addr = {dAddr[31:2], 2'b00}; t.we = dWr; t.wdata = dWdata; t.dly = dDly;
      expQ.push_back(t);
      dDoneExp = 1 + lat(dDly);
      if (dDly == 0) errExp = 1'b1;
      if (dWr) begin
        if (bufTag == dAddr[31:2]) bufValid = 1'b0;
        if (dDly != 0) refMem[idx(dAddr)] = dWdata;
      end else begin
        dDataExp = (dDly == 0) ? 32'h0 : refMem[idx(dAddr)];
      end
      nextFree = dDoneExp + 1;
    end
    if (fEn) begin
      fHit = 1'b0;
`ifdef INST_BUF_EN
      fHit = bufValid && (bufTag == fAddr[31:2]);
`endif
      if (fHit) begin
        fDoneExp = nextFree;
        fDataExp = bufData;
      end else begin
        t.addr = {fAddr[31:2], 2'b00}; t.we = 1'b0; t.wdata = '0; t.dly = fDly;
        expQ.push_back(t);
        fDoneExp = nextFree + 1 + lat(fDly);
        fDataExp = (fDly == 0) ? 32'h0 : refMem[idx(fAddr)];
        if (fDly == 0) begin
          errExp = 1'b1;
        end else begin
          bufValid = 1'b1;
          bufTag   = fAddr[31:2];
          bufData  = fDataExp;
        end
      end
    end

    busAddrLog.delete(); busyLenLog.delete(); gapLog.delete();
    fDone = !fEn; dDone = !dEn; inTxn = 1'b0;
    txnIdx = 0; busyCnt = 0; gapCnt = 0; badBus = 0;
    fDoneCyc = -1; dDoneCyc = -1; fData = '0; dData = '0;

    for (int c = 0; (c < 80) && !(fDone && dDone); c++) begin
      @(negedge clk);
      bus_ack = 1'b0;
      bus_rdata = $urandom;
      if (bus_req) begin
        if (!inTxn) begin
          inTxn = 1'b1;
          busyCnt = 0;
          busAddrLog.push_back(bus_addr);
          if (txnIdx > 0) gapLog.push_back(gapCnt);
        end
        busyCnt++;
        if (txnIdx < expQ.size()) begin
          t = expQ[txnIdx];
          if ((bus_addr !== t.addr) || (bus_we !== t.we) || (t.we && (bus_wdata !== t.wdata)))
            badBus++;
        end else begin
          t.dly = 1;
          badBus++;
        end
        if ((t.dly != 0) && (busyCnt == t.dly)) begin
          bus_ack = 1'b1;
          bus_rdata = busMem[idx(bus_addr)];
          if (bus_we) busMem[idx(bus_addr)] = bus_wdata;
        end
      end else begin
        if (inTxn) begin
          inTxn = 1'b0;
          busyLenLog.push_back(busyCnt);
          txnIdx++;
          gapCnt = 0;
        end
        gapCnt++;
      end

      rom_cs = fEn && !fDone; inst_ren = rom_cs; inst_addr = fAddr;
      ram_cs = dEn && !dDone; mem_wen = ram_cs && dWr; mem_ren = ram_cs && !dWr;
      mem_addr = dAddr; mem_dout = dWdata;
      #1;
      if (!fDone && !rom_stall) begin fDone = 1'b1; fDoneCyc = c; fData = inst_data; end
      if (!dDone && !ram_stall) begin dDone = 1'b1; dDoneCyc = c; dData = mem_din; end
      if (fDone) begin rom_cs = 1'b0; inst_ren = 1'b0; end
      if (dDone) begin ram_cs = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; end
    end
    rom_cs = 1'b0; inst_ren = 1'b0; ram_cs = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;

    if (fEn) begin
      checkOutput("romStallCycles", fDoneCyc, fDoneExp);
      if (fDone) checkOutput("instData", fData, fDataExp);
    end
    if (dEn) begin
      checkOutput("ramStallCycles", dDoneCyc, dDoneExp);
      if (!dWr && dDone) checkOutput("memDin", dData, dDataExp);
    end
    checkOutput("txnCount", busyLenLog.size(), expQ.size());
    for (int i = 0; (i < busyLenLog.size()) && (i < expQ.size()); i++)
      checkOutput("busReqCycles", busyLenLog[i], lat(expQ[i].dly));
    checkOutput("busSignals", badBus, 0);
    checkOutput("busErr", bus_err, errExp);
  endtask

  logic [31:0] pool [6];
  logic [31:0] v, fA, dA, wd;
  int          kind, fD, dD;

  initial begin
    rst_n = 1'b0;
    rom_cs = 1'b0; inst_ren = 1'b0; inst_addr = '0;
    ram_cs = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_dout = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    for (int k = 0; k < 4096; k++) begin
      v = $urandom;
      busMem[k] = v;
      refMem[k] = v;
    end
    busMem[idx(32'h100)] = 32'h2402000A;
    refMem[idx(32'h100)] = 32'h2402000A;
    pool = '{32'h100, 32'h104, 32'h200, 32'h2000, 32'h2004, 32'h3000};

    doReset();

    // Fetch 0x100 with ack in the first BUSY cycle.
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1, 0);
    checkOutput("t1InstData", inst_data, 32'h2402000A);

    // Simultaneous fetch and data read: data goes to the bus first.
    applyStimulus(1'b1, 32'h104, 1'b1, 1'b0, 32'h2000, 32'h0, 1, 1);
    checkOutput("t2FirstAddr", (busAddrLog.size() > 0) ? busAddrLog[0] : 32'hFFFFFFFF, 32'h2000);
    checkOutput("t2SecondAddr", (busAddrLog.size() > 1) ? busAddrLog[1] : 32'hFFFFFFFF, 32'h104);
    checkOutput("t2ReqGap", (gapLog.size() > 0) && (gapLog[0] >= 1), 1);

    // Data write with a three-cycle ack, then read it back.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h3000, 32'hCAFEBABE, 0, 3);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h3000, 32'h0, 0, 1);
    checkOutput("t3ReadBack", mem_din, 32'hCAFEBABE);

    // Ack on the last allowed BUSY cycle still wins over the timeout.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h2004, 32'h0, 0, TIMEOUT);

    // No ack: timeout, zero read data, sticky error.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h2004, 32'h0, 0, 0);
    checkOutput("t4MemDin", mem_din, 32'h0);
    applyStimulus(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, 2, 0);
    checkOutput("t4ErrSticky", bus_err, 1);

    // Reset in the middle of a data transaction, then a stray ack.
    @(negedge clk);
    ram_cs = 1'b1; mem_ren = 1'b1; mem_addr = 32'h2000;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t5BusReqDrop", bus_req, 0);
    checkOutput("t5StallHeld", ram_stall, 1);
    ram_cs = 1'b0; mem_ren = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    checkOutput("t5AckIgnored", mem_din, 32'h0);
    checkOutput("t5NoBusReq", bus_req, 0);
    checkOutput("t5ErrCleared", bus_err, 0);
    errExp = 1'b0; bufValid = 1'b0; bufTag = '0; bufData = '0;

    // Repeated fetch of 0x200, a write to it, then another fetch.
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 2, 0);
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 2, 0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'h12345678, 0, 1);
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 1, 0);
    checkOutput("t6NewData", inst_data, 32'h12345678);

    // Randomised mix of fetches, reads, writes and collisions.
    for (int i = 0; i < 60; i++) begin
      if ((i % 15) == 14) doReset();
      kind = $urandom_range(0, 3);
      fA = pool[$urandom_range(0, 5)];
      dA = pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 3));
      wd = $urandom;
      fD = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TIMEOUT);
      dD = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TIMEOUT);
      case (kind)
        0: applyStimulus(1'b1, fA, 1'b0, 1'b0, dA, wd, fD, dD);
        1: applyStimulus(1'b0, fA, 1'b1, 1'b0, dA, wd, fD, dD);
        2: applyStimulus(1'b0, fA, 1'b1, 1'b1, dA, wd, fD, dD);
        default: applyStimulus(1'b1, fA, 1'b1, ($urandom_range(0, 1) == 1), dA, wd, fD, dD);
      endcase
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
